// File: rtl/fusion_pipe_pkg.sv
// fusion_pipe_pkg: shared pipeline sequencing types and constants for the integer core
package fusion_pipe_pkg;
  localparam int REG_W = 5;
  localparam int PIPE_LEN_DEFAULT = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DRAIN     = 2'd1,
    SYNC_WAIT = 2'd2
  } pipe_state_e;
endpackage

// File: rtl/pipe_hazard_ctrl_32_load_use_detect.sv
// load_use_detect: flags a decode-stage read of a register still being loaded in execute
module load_use_detect
  import fusion_pipe_pkg::*;
(
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] rsa,
  input  logic [REG_W-1:0] rsb,
  output logic             hazard
);
  assign hazard = ex_mem_read && ex_rd != REG_ZERO && (ex_rd == rsa || ex_rd == rsb);
endmodule

// File: rtl/pipe_hazard_ctrl_32.sv
// pipe_hazard_ctrl_32: per-stage stall/flush/bubble sequencing and memsync drain FSM
module pipe_hazard_ctrl_32
  import fusion_pipe_pkg::*;
#(
  parameter int PIPELINE_LENGTH = PIPE_LEN_DEFAULT,
  parameter int SYNC_TIMEOUT = 64,
  localparam int CNT_W = $clog2(SYNC_TIMEOUT + 1)
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [REG_W-1:0] dec_rsa_in,
  input  logic [REG_W-1:0] dec_rsb_in,
  input  logic             dec_memsync_in,
  input  logic             dec_syscall_in,
  input  logic [REG_W-1:0] ex_rd_in,
  input  logic             ex_mem_read_in,
  input  logic             ex_branch_taken_in,
  input  logic             mem_idle_in,
  input  logic             ext_stall_in,
  output logic             stall_fetch_out,
  output logic             stall_decode_out,
  output logic             bubble_ex_out,
  output logic             flush_fetch_out,
  output logic             flush_decode_out,
  output logic             syscall_grant_out,
  output logic             memsync_done_out,
  output logic             sync_err_out,
  output logic [1:0]       state_out
);
  localparam logic [CNT_W-1:0] DRAIN_CNT = CNT_W'(PIPELINE_LENGTH - 2);
  pipe_state_e st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic pend, pend_n, err_n, done_n, grant_n;
  logic hazard, stall, bubble, flush;
  load_use_detect u_lud (
    .ex_rd       (ex_rd_in),
    .ex_mem_read (ex_mem_read_in),
    .rsa         (dec_rsa_in),
    .rsb         (dec_rsb_in),
    .hazard      (hazard)
  );
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    pend_n = pend;
    err_n = sync_err_out;
    done_n = 1'b0;
    grant_n = 1'b0;
    stall = 1'b0;
    bubble = 1'b0;
    flush = 1'b0;
    case (st)
      RUN: begin
        flush = ex_branch_taken_in;
        stall = !ex_branch_taken_in && hazard;
        bubble = !ex_branch_taken_in && (hazard || dec_memsync_in);
        if (!ex_branch_taken_in && !hazard && dec_memsync_in) begin
          st_n = DRAIN;
          cnt_n = DRAIN_CNT;
          pend_n = dec_syscall_in;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        bubble = 1'b1;
        cnt_n = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          st_n = SYNC_WAIT;
          cnt_n = '0;
        end
      end
      SYNC_WAIT: begin
        stall = 1'b1;
        bubble = 1'b1;
        cnt_n = cnt + 1'b1;
        if (mem_idle_in) begin
          st_n = RUN;
          done_n = 1'b1;
          grant_n = pend;
          pend_n = 1'b0;
        end else if (cnt_n == CNT_W'(SYNC_TIMEOUT)) begin
          st_n = RUN;
          err_n = 1'b1;
        end
      end
      default: st_n = RUN;
    endcase
    // a freeze holds everything except recovery from the illegal encoding
    if (ext_stall_in) begin
      stall = 1'b1;
      bubble = 1'b0;
      flush = 1'b0;
      st_n = (st == RUN || st == DRAIN || st == SYNC_WAIT) ? st : RUN;
      cnt_n = cnt;
      pend_n = pend;
      err_n = sync_err_out;
      done_n = 1'b0;
      grant_n = 1'b0;
    end
  end
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      st <= RUN;
      cnt <= '0;
      pend <= 1'b0;
      sync_err_out <= 1'b0;
      memsync_done_out <= 1'b0;
      syscall_grant_out <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      pend <= pend_n;
      sync_err_out <= err_n;
      memsync_done_out <= done_n;
      syscall_grant_out <= grant_n;
    end
  end
  assign stall_fetch_out = stall && !reset_in;
  assign stall_decode_out = stall && !reset_in;
  assign bubble_ex_out = bubble && !reset_in;
  assign flush_fetch_out = flush && !reset_in;
  assign flush_decode_out = flush && !reset_in;
  assign state_out = st;
endmodule

// File: tb/tb_pipe_hazard_ctrl_32.sv
// tb_pipe_hazard_ctrl_32: directed vectors and multi-cycle sequences for the hazard controller
module tb_pipe_hazard_ctrl_32;
  logic clk_in = 1'b0, reset_in = 1'b1;
  logic [4:0] dec_rsa_in = '0, dec_rsb_in = '0, ex_rd_in = '0;
  logic dec_memsync_in = 0, dec_syscall_in = 0, ex_mem_read_in = 0;
  logic ex_branch_taken_in = 0, mem_idle_in = 0, ext_stall_in = 0;
  logic stall_fetch_out, stall_decode_out, bubble_ex_out, flush_fetch_out, flush_decode_out;
  logic syscall_grant_out, memsync_done_out, sync_err_out;
  logic [1:0] state_out;
  int checks = 0, errors = 0;

  pipe_hazard_ctrl_32 dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .dec_rsa_in(dec_rsa_in), .dec_rsb_in(dec_rsb_in),
    .dec_memsync_in(dec_memsync_in), .dec_syscall_in(dec_syscall_in),
    .ex_rd_in(ex_rd_in), .ex_mem_read_in(ex_mem_read_in),
    .ex_branch_taken_in(ex_branch_taken_in), .mem_idle_in(mem_idle_in),
    .ext_stall_in(ext_stall_in),
    .stall_fetch_out(stall_fetch_out), .stall_decode_out(stall_decode_out),
    .bubble_ex_out(bubble_ex_out), .flush_fetch_out(flush_fetch_out),
    .flush_decode_out(flush_decode_out), .syscall_grant_out(syscall_grant_out),
    .memsync_done_out(memsync_done_out), .sync_err_out(sync_err_out),
    .state_out(state_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0] rsa, rsb, rd;
    logic mr, ms, br, ext;
    logic [2:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [4:0] outs;
    return {stall_fetch_out, stall_decode_out, bubble_ex_out, flush_fetch_out, flush_decode_out};
  endfunction

  function automatic logic [4:0] expand(input logic [2:0] e);
    return {e[2], e[2], e[1], e[0], e[0]};
  endfunction

  initial begin
    vec_t v [8];
    int n;
    // exp = {stall, bubble, flush}
    v[0] = '{rsa:0, rsb:0, rd:0, mr:0, ms:0, br:0, ext:0, exp:3'b000};
    v[1] = '{rsa:0, rsb:5, rd:5, mr:1, ms:0, br:0, ext:0, exp:3'b110};
    v[2] = '{rsa:0, rsb:0, rd:0, mr:1, ms:0, br:0, ext:0, exp:3'b000};
    v[3] = '{rsa:0, rsb:5, rd:5, mr:0, ms:0, br:0, ext:0, exp:3'b000};
    v[4] = '{rsa:7, rsb:2, rd:7, mr:1, ms:0, br:0, ext:0, exp:3'b110};
    v[5] = '{rsa:3, rsb:4, rd:7, mr:1, ms:0, br:0, ext:0, exp:3'b000};
    v[6] = '{rsa:0, rsb:5, rd:5, mr:1, ms:1, br:1, ext:0, exp:3'b001};
    v[7] = '{rsa:0, rsb:5, rd:5, mr:1, ms:1, br:1, ext:1, exp:3'b100};

    #2;
    chk("reset_ctrl", 32'(outs()), 0);
    chk("reset_state", 32'(state_out), 0);
    chk("reset_pulses", 32'({memsync_done_out, syscall_grant_out, sync_err_out}), 0);
    @(negedge clk_in);
    reset_in = 0;
    step();

    foreach (v[i]) begin
      dec_rsa_in = v[i].rsa; dec_rsb_in = v[i].rsb; ex_rd_in = v[i].rd;
      ex_mem_read_in = v[i].mr; dec_memsync_in = v[i].ms;
      ex_branch_taken_in = v[i].br; ext_stall_in = v[i].ext;
      #1;
      chk($sformatf("vec%0d_ctrl", i), 32'(outs()), 32'(expand(v[i].exp)));
      step();
      chk($sformatf("vec%0d_state", i), 32'(state_out), 0);
    end
    dec_rsa_in = 0; dec_rsb_in = 0; ex_rd_in = 0; ex_mem_read_in = 0;
    dec_memsync_in = 0; ex_branch_taken_in = 0; ext_stall_in = 0;

    // load-use clears once the bubble sits in EX
    ex_mem_read_in = 1; ex_rd_in = 5; dec_rsb_in = 5;
    #1 chk("lu_cycle1", 32'(outs()), 32'(5'b11100));
    step();
    ex_mem_read_in = 0; ex_rd_in = 0;
    #1 chk("lu_cycle2", 32'(outs()), 0);
    dec_rsb_in = 0;
    step();

    // syscall sync with immediate idle
    dec_memsync_in = 1; dec_syscall_in = 1; mem_idle_in = 1;
    #1 chk("ms_enter_ctrl", 32'(outs()), 32'(5'b00100));
    chk("ms_seq0", 32'(state_out), 0);
    step();
    dec_memsync_in = 0; dec_syscall_in = 0;
    chk("ms_seq1", 32'(state_out), 1);
    chk("ms_drain_ctrl", 32'(outs()), 32'(5'b11100));
    step(); chk("ms_seq2", 32'(state_out), 1);
    step(); chk("ms_seq3", 32'(state_out), 1);
    step(); chk("ms_seq4", 32'(state_out), 2);
    chk("ms_no_early_done", 32'(memsync_done_out), 0);
    step(); chk("ms_seq5", 32'(state_out), 0);
    chk("ms_done_grant", 32'({memsync_done_out, syscall_grant_out}), 32'(2'b11));
    step();
    chk("ms_pulse_end", 32'({memsync_done_out, syscall_grant_out}), 0);

    // external freeze lengthens the drain by its duration
    dec_memsync_in = 1;
    step();
    dec_memsync_in = 0;
    n = 1;
    repeat (4) begin
      ext_stall_in = 1;
      #1 chk("frz_ctrl", 32'(outs()), 32'(5'b11000));
      chk("frz_state", 32'(state_out), 1);
      step();
      n++;
    end
    ext_stall_in = 0;
    while (!memsync_done_out && n < 50) begin
      step();
      n++;
    end
    chk("frz_latency", 32'(n), 9);
    chk("frz_no_grant", 32'(syscall_grant_out), 0);
    step();

    // timeout with memory never idle
    mem_idle_in = 0;
    dec_memsync_in = 1;
    step();
    dec_memsync_in = 0;
    step(); step(); step();
    chk("to_enter_wait", 32'(state_out), 2);
    n = 0;
    while (state_out == 2 && n < 200) begin
      chk("to_no_err_yet", 32'(sync_err_out), 0);
      step();
      n++;
    end
    chk("to_wait_cycles", 32'(n), 64);
    chk("to_state", 32'(state_out), 0);
    chk("to_err", 32'(sync_err_out), 1);
    chk("to_no_done", 32'(memsync_done_out), 0);
    step(); step();
    chk("to_err_sticky", 32'(sync_err_out), 1);

    // asynchronous reset while waiting for sync
    dec_memsync_in = 1;
    step();
    dec_memsync_in = 0;
    step(); step(); step();
    chk("rst_pre_state", 32'(state_out), 2);
    #2;
    reset_in = 1; ex_branch_taken_in = 1;
    #1;
    chk("rst_async_ctrl", 32'(outs()), 0);
    chk("rst_async_state", 32'(state_out), 0);
    chk("rst_async_err", 32'(sync_err_out), 0);
    step();
    reset_in = 0; ex_branch_taken_in = 0;
    step();
    chk("rst_after_state", 32'(state_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl_32.md
Name: pipe_hazard_ctrl_32

Overview:
- Central pipeline sequencer for the 5-stage integer core: fetch, decode, execute, memory, writeback.
- Takes decoded operand/control signals from decode_32 and status from execute/memory.
- Generates per-stage stall, flush and bubble controls. Resolves load-use hazards, taken-branch flushes and the memory-sync/syscall drain sequence.
- Replaces the ad-hoc memsync stall counter inside the decoder with a single owner of pipeline sequencing.

Parameters:
- PIPELINE_LENGTH, 5, number of pipeline stages. Drain count is PIPELINE_LENGTH-2, i.e. the stages downstream of decode.
- SYNC_TIMEOUT, 64, maximum SYNC_WAIT cycles before sync_err_out is raised.
- CNT_W, $clog2(SYNC_TIMEOUT+1), width of the shared drain/timeout counter. Derived; do not override.

Ports:
- clk_in  input  1  core clock
- reset_in  input  1  asynchronous, active-high reset
- dec_rsa_in  input  5  decode-stage source A address (0 = unused)
- dec_rsb_in  input  5  decode-stage source B address (0 = unused)
- dec_memsync_in  input  1  decode stage holds a memsync or syscall
- dec_syscall_in  input  1  decode stage holds a syscall
- ex_rd_in  input  5  execute-stage destination address
- ex_mem_read_in  input  1  execute stage holds a load
- ex_branch_taken_in  input  1  execute resolved a taken branch or jump
- mem_idle_in  input  1  memory system has no outstanding transactions
- ext_stall_in  input  1  external freeze (cache miss, co-processor busy)
- stall_fetch_out  output  1  hold the PC and fetch register
- stall_decode_out  output  1  hold the decode register (drives decode_32 stall_in)
- bubble_ex_out  output  1  inject a NOP into the execute register
- flush_fetch_out  output  1  squash the instruction in fetch
- flush_decode_out  output  1  squash the instruction in decode
- syscall_grant_out  output  1  one-cycle pulse: syscall may trap
- memsync_done_out  output  1  one-cycle pulse: sync sequence complete
- sync_err_out  output  1  sticky: SYNC_WAIT timed out
- state_out  output  2  current FSM state, for debug

Behaviour:
- Reset (asynchronous): state=RUN, counter=0, sync_err_out=0, syscall_pend=0.
- All control outputs are Mealy combinational from state and inputs. The pulses and sync_err_out are registered.
- During reset every output is 0, and state_out=RUN.
- FSM states: RUN=0, DRAIN=1, SYNC_WAIT=2. Encoding 3 is illegal; on the next clock it goes to RUN.
- Priority within a cycle, highest first: ext_stall_in, ex_branch_taken_in, load-use, memsync.
- ext_stall_in=1, any state:
  - stall_fetch_out=1 and stall_decode_out=1.
  - No bubble and no flush.
  - Counter and state frozen; the SYNC_WAIT timeout does not advance.
- RUN, taken branch:
  - flush_fetch_out=1 and flush_decode_out=1 for that one cycle.
  - No stall.
  - A memsync in decode is squashed, so there is no transition.
- RUN, load-use hazard:
  - Condition: ex_mem_read_in=1, ex_rd_in!=0, and ex_rd_in equals dec_rsa_in or dec_rsb_in.
  - Response: stall_fetch_out=1, stall_decode_out=1, bubble_ex_out=1 for exactly that cycle.
  - The next cycle the EX stage holds the bubble, so the hazard clears.
- RUN, dec_memsync_in=1 with no higher-priority event:
  - Go to DRAIN next cycle.
  - Load counter=PIPELINE_LENGTH-2.
  - Set syscall_pend=dec_syscall_in.
  - Assert bubble_ex_out in this cycle. The sync instruction itself advances into EX.
- DRAIN:
  - stall_fetch_out=1, stall_decode_out=1, bubble_ex_out=1.
  - Counter decrements each non-frozen cycle.
  - When counter=1 while decrementing, go to SYNC_WAIT with counter=0.
- SYNC_WAIT:
  - Outputs as in DRAIN.
  - Counter increments each non-frozen cycle.
  - If mem_idle_in=1: go to RUN and pulse memsync_done_out next cycle. If syscall_pend=1, also pulse syscall_grant_out; clear syscall_pend.
  - Else if counter reaches SYNC_TIMEOUT: set sync_err_out (sticky until reset) and go to RUN. No done or grant pulse is issued.
- Taken branch during DRAIN or SYNC_WAIT cannot occur, because EX holds bubbles. It is ignored.
- Latency from memsync in decode to memsync_done_out, with PIPELINE_LENGTH=5 and immediate idle: 1 + 3 + 1 = 5 cycles.
- Register address 0 never creates a hazard.

Decomposition:
- Package fusion_pipe_pkg:
  - state enum (RUN, DRAIN, SYNC_WAIT)
  - PIPELINE_LENGTH default
  - REG_ZERO constant
  - also to be used by decode_32
- Sub-module load_use_detect (combinational): inputs ex_rd, ex_mem_read, rsa, rsb; output hazard.
- The FSM and counter stay in the top module.

Test Plan:
- Load r5 in EX (ex_mem_read_in=1, ex_rd_in=5) with dec_rsb_in=5 -> exactly one cycle of stall_fetch/stall_decode/bubble_ex=1. Repeat with ex_rd_in=0 -> no stall.
- ex_branch_taken_in=1 together with a load-use hazard and dec_memsync_in=1 -> flush_fetch/flush_decode=1, no stall, state stays RUN.
- dec_memsync_in=1, dec_syscall_in=1, mem_idle_in=1 -> DRAIN for 3 cycles, 1 SYNC_WAIT cycle, then memsync_done_out and syscall_grant_out pulse together at cycle 5; state_out sequence 0,1,1,1,2,0.
- Memsync with mem_idle_in held 0 -> after 64 SYNC_WAIT cycles sync_err_out=1 (sticky), return to RUN, no done pulse.
- ext_stall_in=1 for 4 cycles mid-DRAIN -> counter frozen, bubble_ex_out=0 while frozen, total sequence lengthened by exactly 4 cycles.
- reset_in asserted mid-SYNC_WAIT between clock edges -> outputs 0 immediately, state_out=0, sync_err_out cleared.
